// File: rtl/eth_proto_tx.sv
`default_nettype none
// ============================================================================
//  Module      : eth_proto_tx
//  Description : Protocol frame transmitter. Accepts one packed protocol frame
//                and serialises it MSB-byte-first onto an 8-bit valid/ready
//                stream toward the Ethernet MAC, with optional zero padding up
//                to a minimum length and a fixed idle gap after every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_proto_tx #(
  parameter int FRM_BYTES  = 28,
  parameter int PAD_BYTES  = 0,
  parameter int IFG_CYCLES = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FRM_BYTES*8-1:0] frame_i,
  input  logic                   frame_valid_i,
  output logic                   frame_ready_o,
  output logic [7:0]             mac_data_o,
  output logic                   mac_valid_o,
  input  logic                   mac_ready_i,
  output logic                   tx_done_o,
  output logic                   busy_o
);

  // Total emitted bytes per frame: frame bytes, or the pad minimum if larger.
  localparam int c_tot     = (PAD_BYTES > FRM_BYTES) ? PAD_BYTES : FRM_BYTES;
  localparam bit c_has_pad = (PAD_BYTES > FRM_BYTES);
  localparam int c_w       = FRM_BYTES * 8;
  // Byte counter is wide enough to hold c_tot itself, so it never wraps.
  localparam int c_cw      = $clog2(c_tot + 1);
  localparam int c_gw      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [c_cw-1:0] c_frm_last = c_cw'(FRM_BYTES - 1);
  localparam logic [c_cw-1:0] c_tot_last = c_cw'(c_tot - 1);
  localparam logic [c_gw-1:0] c_gap_last = c_gw'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAD  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [c_w-1:0]    r_shift;
  logic [c_cw-1:0]   r_byte_cnt;
  logic [c_gw-1:0]   r_gap_cnt;
  logic              r_done;

  logic              w_accept;
  logic              w_mac_hs;
  logic              w_last_frm;
  logic              w_last_tot;
  logic              w_gap_end;
  logic              w_frame_end;

  // Handshake and terminal-count decodes, all derived from registered state.
  assign w_accept    = frame_valid_i && (r_state == ST_IDLE) && rst_n;
  assign w_mac_hs    = mac_ready_i && ((r_state == ST_SEND) || (r_state == ST_PAD));
  assign w_last_frm  = (r_byte_cnt == c_frm_last);
  assign w_last_tot  = (r_byte_cnt == c_tot_last);
  assign w_gap_end   = (r_gap_cnt == c_gap_last);
  // Last byte of the whole emitted frame (pad included) handed to the MAC.
  assign w_frame_end = w_mac_hs &&
                       (((r_state == ST_SEND) && w_last_frm && !c_has_pad) ||
                        ((r_state == ST_PAD) && w_last_tot));

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and stream outputs.
  always_comb begin
    w_next_state  = r_state;
    frame_ready_o = 1'b0;
    mac_valid_o   = 1'b0;
    mac_data_o    = 8'h00;
    busy_o        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        // Ready is gated by reset so every output reads zero while held.
        frame_ready_o = rst_n;
        busy_o        = 1'b0;
        if (w_accept) begin
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        mac_valid_o = 1'b1;
        mac_data_o  = r_shift[c_w-1 -: 8];
        if (w_mac_hs && w_last_frm) begin
          w_next_state = c_has_pad ? ST_PAD : ST_GAP;
        end
      end
      ST_PAD: begin
        mac_valid_o = 1'b1;
        if (w_mac_hs && w_last_tot) begin
          w_next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_gap_end) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        busy_o       = 1'b0;
      end
    endcase
  end

  // Frame shift register and byte counter: load on accept, advance per MAC byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (w_accept) begin
      r_shift    <= frame_i;
      r_byte_cnt <= '0;
    end else if (w_mac_hs) begin
      if (r_state == ST_SEND) begin
        r_shift <= r_shift << 8;
      end
      r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  // Inter-frame gap counter; runs only while in the gap state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
    end else if ((r_state == ST_GAP) && !w_gap_end) begin
      r_gap_cnt <= r_gap_cnt + 1'b1;
    end else begin
      r_gap_cnt <= '0;
    end
  end

  // Completion pulse lands in the first gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_frame_end;
    end
  end

  assign tx_done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_eth_proto_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_proto_tx
//  Description : Directed bench for eth_proto_tx: unpadded ARP frame, MAC
//                back-pressure, zero padding to 46 bytes, back-to-back frames
//                and reset in mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_proto_tx;

  logic         clk;
  logic         rst_n;
  logic [223:0] frame;

  // Unpadded instance
  logic         fv0, fr0, mv0, mr0, done0, busy0;
  logic [7:0]   md0;
  // Padded instance (46-byte minimum)
  logic         fv1, fr1, mv1, mr1, done1, busy1;
  logic [7:0]   md1;

  int checks;
  int errors;

  logic [7:0] exp_b [28];

  eth_proto_tx #(.FRM_BYTES(28), .PAD_BYTES(0), .IFG_CYCLES(12)) dut (
    .clk(clk), .rst_n(rst_n), .frame_i(frame), .frame_valid_i(fv0),
    .frame_ready_o(fr0), .mac_data_o(md0), .mac_valid_o(mv0),
    .mac_ready_i(mr0), .tx_done_o(done0), .busy_o(busy0)
  );

  eth_proto_tx #(.FRM_BYTES(28), .PAD_BYTES(46), .IFG_CYCLES(12)) dut_pad (
    .clk(clk), .rst_n(rst_n), .frame_i(frame), .frame_valid_i(fv1),
    .frame_ready_o(fr1), .mac_data_o(md1), .mac_valid_o(mv1),
    .mac_ready_i(mr1), .tx_done_o(done1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int rdy_hi;
    int vhi;
    checks = 0;
    errors = 0;

    // ARP reply: htype 1, ptype 0800, hlen 6, plen 4, oper 2,
    // sha 02:00:00:00:00:01, spa 192.168.0.1, tha 02:00:00:00:00:02, tpa 192.168.0.2
    exp_b[0]  = 8'h00; exp_b[1]  = 8'h01; exp_b[2]  = 8'h08; exp_b[3]  = 8'h00;
    exp_b[4]  = 8'h06; exp_b[5]  = 8'h04; exp_b[6]  = 8'h00; exp_b[7]  = 8'h02;
    exp_b[8]  = 8'h02; exp_b[9]  = 8'h00; exp_b[10] = 8'h00; exp_b[11] = 8'h00;
    exp_b[12] = 8'h00; exp_b[13] = 8'h01; exp_b[14] = 8'hc0; exp_b[15] = 8'ha8;
    exp_b[16] = 8'h00; exp_b[17] = 8'h01; exp_b[18] = 8'h02; exp_b[19] = 8'h00;
    exp_b[20] = 8'h00; exp_b[21] = 8'h00; exp_b[22] = 8'h00; exp_b[23] = 8'h02;
    exp_b[24] = 8'hc0; exp_b[25] = 8'ha8; exp_b[26] = 8'h00; exp_b[27] = 8'h02;
    for (int i = 0; i < 28; i++) frame[(27 - i) * 8 +: 8] = exp_b[i];

    rst_n = 1'b0;
    fv0 = 1'b0; mr0 = 1'b1;
    fv1 = 1'b0; mr1 = 1'b1;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_ready", fr0, 0);
    check("rst_valid", mv0, 0);
    check("rst_data",  md0, 0);
    check("rst_done",  done0, 0);
    check("rst_busy",  busy0, 0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", fr0, 1);
    check("rel_busy",  busy0, 0);
    tick();

    // ---------------- T1: plain ARP frame ----------------
    fv0 = 1'b1;
    tick();                      // accept edge
    fv0 = 1'b0;
    check("t1_ready_after_acc", fr0, 0);
    check("t1_busy", busy0, 1);
    for (int i = 0; i < 28; i++) begin
      check($sformatf("t1_valid[%0d]", i), mv0, 1);
      check($sformatf("t1_byte[%0d]", i), md0, exp_b[i]);
      check($sformatf("t1_nodone[%0d]", i), done0, 0);
      tick();
    end
    check("t1_done", done0, 1);
    check("t1_gap_valid", mv0, 0);
    check("t1_gap_data", md0, 0);
    n = 0;
    while (!fr0 && n < 40) begin
      tick();
      n++;
    end
    // Ready returns IFG_CYCLES cycles after the done pulse.
    check("t1_ifg_to_ready", n, 12);
    check("t1_done_cleared", done0, 0);

    // ---------------- T2: back-pressure on byte 5 ----------------
    fv0 = 1'b1;
    tick();
    fv0 = 1'b0;
    frame = {28{8'hff}};         // must not disturb the frame in flight
    for (int i = 0; i < 28; i++) begin
      check($sformatf("t2_byte[%0d]", i), md0, exp_b[i]);
      if (i == 5) begin
        mr0 = 1'b0;
        repeat (3) begin
          tick();
          check("t2_stall_valid", mv0, 1);
          check("t2_stall_byte", md0, 8'h04);
        end
        mr0 = 1'b1;
      end
      tick();
    end
    check("t2_done", done0, 1);
    for (int i = 0; i < 28; i++) frame[(27 - i) * 8 +: 8] = exp_b[i];
    n = 0;
    while (!fr0 && n < 40) begin
      tick();
      n++;
    end
    check("t2_back_idle", fr0, 1);

    // ---------------- T3: padding to 46 bytes ----------------
    check("t3_pad_ready", fr1, 1);
    fv1 = 1'b1;
    tick();
    fv1 = 1'b0;
    for (int i = 0; i < 46; i++) begin
      check($sformatf("t3_valid[%0d]", i), mv1, 1);
      check($sformatf("t3_byte[%0d]", i), md1, (i < 28) ? exp_b[i] : 8'h00);
      check($sformatf("t3_nodone[%0d]", i), done1, 0);
      tick();
    end
    check("t3_done", done1, 1);
    check("t3_gap_valid", mv1, 0);

    // ---------------- T4: back-to-back frames ----------------
    fv0 = 1'b1;
    tick();
    for (int i = 0; i < 28; i++) begin
      check($sformatf("t4_f1_byte[%0d]", i), md0, exp_b[i]);
      check($sformatf("t4_f1_ready[%0d]", i), fr0, 0);
      tick();
    end
    n = 0;
    rdy_hi = 0;
    while (!mv0 && n < 40) begin
      if (fr0) rdy_hi++;
      n++;
      tick();
    end
    // 12 gap cycles plus the single idle cycle in which frame 2 is accepted.
    check("t4_valid_low_cycles", n, 13);
    check("t4_ready_high_cycles", rdy_hi, 1);
    fv0 = 1'b0;
    for (int i = 0; i < 28; i++) begin
      check($sformatf("t4_f2_byte[%0d]", i), md0, exp_b[i]);
      tick();
    end
    check("t4_f2_done", done0, 1);
    n = 0;
    while (!fr0 && n < 40) begin
      tick();
      n++;
    end
    check("t4_f2_ifg", n, 12);

    // ---------------- T5: reset mid-frame ----------------
    fv0 = 1'b1;
    tick();
    fv0 = 1'b0;
    for (int i = 0; i < 11; i++) tick();   // bytes 0..10 handed over
    check("t5_byte11", md0, exp_b[11]);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", mv0, 0);
    check("t5_rst_data",  md0, 0);
    check("t5_rst_ready", fr0, 0);
    check("t5_rst_busy",  busy0, 0);
    check("t5_rst_done",  done0, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("t5_rel_ready", fr0, 1);
    vhi = 0;
    for (int i = 0; i < 40; i++) begin
      if (mv0 || busy0 || done0) vhi++;
      tick();
    end
    check("t5_no_residue", vhi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
